multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM for the multicycle RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the mux selects, write strobes, ALU control and the immediate-format select `imm_src_o` that feeds the sign-extension unit. It sits beside the datapath, consumes the IR fields and the ALU zero flag, and stalls on a shared instruction/data memory through a ready handshake.

## Interface
- No parameters.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `op_i`  in  7  IR[6:0] opcode.
- `funct3_i`  in  3  IR[14:12].
- `funct7b5_i`  in  1  IR[30].
- `zero_i`  in  1  ALU zero flag for the current ALU operation.
- `mem_ready_i`  in  1  memory completes the current access this cycle.
- `pc_write_o`  out  1  PC register load enable.
- `adr_src_o`  out  1  memory address select: 0 = PC, 1 = Result.
- `mem_write_o`  out  1  memory write strobe.
- `ir_write_o`  out  1  IR and OldPC load enable.
- `reg_write_o`  out  1  register-file write enable.
- `result_src_o`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a_o`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `alu_src_b_o`  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `alu_control_o`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `imm_src_o`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal_o`  out  1  one-cycle pulse when an unsupported instruction is decoded.

## Operation
- Supported opcodes:
  - lw = 0000011
  - sw = 0100011
  - R-type = 0110011
  - I-ALU = 0010011
  - branch = 1100011; funct3 000 is beq, 001 is bne
  - jal = 1101111
- States and transitions:
  - FETCH → DECODE when `mem_ready_i`; otherwise stay in FETCH.
  - DECODE branches on opcode:
    - lw or sw → MEMADR
    - R-type → EXECUTER
    - I-ALU → EXECUTEI
    - branch with a valid funct3 → BRANCH
    - jal → JAL
    - anything else → FETCH, with `illegal_o` asserted.
  - MEMADR → MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD → MEMWB when `mem_ready_i`; otherwise stay.
  - MEMWRITE → FETCH when `mem_ready_i`; otherwise stay.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, ALUWB and BRANCH → FETCH.
- Outputs per state. Any output not listed is 0; `result_src_o`, `alu_src_a_o` and `alu_src_b_o` default to 00.
  - FETCH: `adr_src_o`=0, A=00, B=10, add, `result_src_o`=10. `ir_write_o` and `pc_write_o` equal `mem_ready_i`.
  - DECODE: A=01, B=01, add. This precomputes the branch target into ALUOut.
  - MEMADR: A=10, B=01, add.
  - MEMREAD: `result_src_o`=00, `adr_src_o`=1.
  - MEMWRITE: `result_src_o`=00, `adr_src_o`=1, `mem_write_o`=1 held until the cycle `mem_ready_i` is high.
  - MEMWB: `result_src_o`=01, `reg_write_o`=1.
  - EXECUTER: A=10, B=00, function decode.
  - EXECUTEI: A=10, B=01, function decode.
  - ALUWB: `result_src_o`=00, `reg_write_o`=1.
  - BRANCH: A=10, B=00, sub, `result_src_o`=00. `pc_write_o` = `zero_i` for beq, `~zero_i` for bne.
  - JAL: A=01, B=10, add, `result_src_o`=00, `pc_write_o`=1.
- Function decode, by funct3:
  - 000: sub if `op_i[5]` & `funct7b5_i`, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- `imm_src_o` is a combinational function of `op_i` in every state:
  - sw → 01
  - branch → 10
  - jal → 11
  - everything else → 00
- All outputs are combinational from the state register and the inputs. Only the state register is sequential.

## Timing
- Reset: the state is forced to FETCH asynchronously the moment `rst_i` rises, regardless of the clock. While reset is held, outputs take their FETCH values. `pc_write_o` and `ir_write_o` follow `mem_ready_i`; the datapath registers hold in reset anyway.
- Reset mid-instruction abandons the instruction. No writeback or memory strobe is issued after `rst_i` rises.
- Cycles per instruction with `mem_ready_i` tied high:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-ALU: 4
  - jal: 4
  - branch: 3
  - illegal: 2
- Each low cycle of `mem_ready_i` in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes are re-driven every stalled cycle. `mem_write_o` stays high through a MEMWRITE stall.
- `illegal_o` is high only in the DECODE cycle of an unsupported opcode or branch funct3.

## Test plan
- Reset asserted mid-MEMWRITE on a non-clock edge → state is FETCH immediately and `mem_write_o`=0 at once. After release, FETCH with `mem_ready_i`=1 → `ir_write_o`=1, `pc_write_o`=1, `alu_src_b_o`=10.
- lw (op 0000011) with ready always high → states in order: FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `imm_src_o`=00. `reg_write_o`=1 only in cycle 5 with `result_src_o`=01.
- sw with `mem_ready_i` low for 3 cycles in MEMWRITE → `mem_write_o` high for 4 consecutive cycles, `imm_src_o`=01, then FETCH.
- R-type sub (funct3 000, `funct7b5_i`=1) → `alu_control_o`=001 in EXECUTER. The same fields under the I-ALU opcode (0010011) → `alu_control_o`=000 (addi).
- beq with `zero_i`=1 → `pc_write_o`=1 in BRANCH, `imm_src_o`=10. bne with `zero_i`=1 → `pc_write_o`=0. Both complete in 3 cycles.
- jal → `imm_src_o`=11, JAL state drives `pc_write_o`=1 with A=01, B=10. Opcode 0110111 → `illegal_o` pulses for 1 cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_controller_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       mem_ready_i;

  logic       pc_write_o;
  logic       adr_src_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic [1:0] result_src_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_control_o;
  logic [1:0] imm_src_o;
  logic       illegal_o;

  modport master (
    input  op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    output pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
           result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
           imm_src_o, illegal_o
  );

  modport slave (
    output op_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
    input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
           result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
           imm_src_o, illegal_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and strobes.
module multicycle_controller (
  input  logic                    clk_i,
  input  logic                    rst_i,
  multicycle_controller_if.master bus
);

  localparam int unsigned OP_W  = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  state_e state_q, state_d;

  // ALU function decode shared by EXECUTER and EXECUTEI; sub only for R-type with funct7b5
  function automatic logic [ALU_W-1:0] alu_decode(input logic            op5,
                                                   input logic [F3_W-1:0] f3,
                                                   input logic            f7b5);
    logic [ALU_W-1:0] ctl;
    ctl = ALU_ADD;
    unique case (f3)
      3'b000:  ctl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Immediate format depends only on the opcode, independent of state
  always_comb begin
    bus.imm_src_o = IMM_I;
    unique case (bus.op_i)
      OP_SW:     bus.imm_src_o = IMM_S;
      OP_BRANCH: bus.imm_src_o = IMM_B;
      OP_JAL:    bus.imm_src_o = IMM_J;
      default:   bus.imm_src_o = IMM_I;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    bus.pc_write_o     = 1'b0;
    bus.adr_src_o      = 1'b0;
    bus.mem_write_o    = 1'b0;
    bus.ir_write_o     = 1'b0;
    bus.reg_write_o    = 1'b0;
    bus.result_src_o   = RES_ALUOUT;
    bus.alu_src_a_o    = SRCA_PC;
    bus.alu_src_b_o    = SRCB_RS2;
    bus.alu_control_o  = ALU_ADD;
    bus.illegal_o      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus.alu_src_a_o  = SRCA_PC;
        bus.alu_src_b_o  = SRCB_FOUR;
        bus.result_src_o = RES_ALURES;
        bus.ir_write_o   = bus.mem_ready_i;
        bus.pc_write_o   = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        bus.alu_src_a_o = SRCA_OLDPC;
        bus.alu_src_b_o = SRCB_IMM;
        unique case (bus.op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_IALU:      state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BRANCH: begin
            if (bus.funct3_i == 3'b000 || bus.funct3_i == 3'b001) begin
              state_d = S_BRANCH;
            end else begin
              state_d       = S_FETCH;
              bus.illegal_o = 1'b1;
            end
          end
          default: begin
            state_d       = S_FETCH;
            bus.illegal_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a_o = SRCA_RS1;
        bus.alu_src_b_o = SRCB_IMM;
        state_d         = (bus.op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.result_src_o = RES_ALUOUT;
        bus.adr_src_o    = 1'b1;
        if (bus.mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        // Strobe held through the stall until memory accepts the write
        bus.result_src_o = RES_ALUOUT;
        bus.adr_src_o    = 1'b1;
        bus.mem_write_o  = 1'b1;
        if (bus.mem_ready_i) state_d = S_FETCH;
      end
      S_MEMWB: begin
        bus.result_src_o = RES_DATA;
        bus.reg_write_o  = 1'b1;
        state_d          = S_FETCH;
      end
      S_EXECR: begin
        bus.alu_src_a_o   = SRCA_RS1;
        bus.alu_src_b_o   = SRCB_RS2;
        bus.alu_control_o = alu_decode(bus.op_i[5], bus.funct3_i, bus.funct7b5_i);
        state_d           = S_ALUWB;
      end
      S_EXECI: begin
        bus.alu_src_a_o   = SRCA_RS1;
        bus.alu_src_b_o   = SRCB_IMM;
        bus.alu_control_o = alu_decode(bus.op_i[5], bus.funct3_i, bus.funct7b5_i);
        state_d           = S_ALUWB;
      end
      S_ALUWB: begin
        bus.result_src_o = RES_ALUOUT;
        bus.reg_write_o  = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq
        bus.alu_src_a_o   = SRCA_RS1;
        bus.alu_src_b_o   = SRCB_RS2;
        bus.alu_control_o = ALU_SUB;
        bus.result_src_o  = RES_ALUOUT;
        bus.pc_write_o    = bus.funct3_i[0] ? ~bus.zero_i : bus.zero_i;
        state_d           = S_FETCH;
      end
      S_JAL: begin
        bus.alu_src_a_o   = SRCA_OLDPC;
        bus.alu_src_b_o   = SRCB_FOUR;
        bus.alu_control_o = ALU_ADD;
        bus.result_src_o  = RES_ALUOUT;
        bus.pc_write_o    = 1'b1;
        state_d           = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each cycle's full control word is
// compared against a hand-written expected word.
module tb_multicycle_controller;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [18:0] obs_w;
  assign obs_w = {bus.pc_write_o, bus.adr_src_o, bus.mem_write_o, bus.ir_write_o,
                  bus.reg_write_o, bus.result_src_o, bus.alu_src_a_o, bus.alu_src_b_o,
                  bus.alu_control_o, bus.imm_src_o, bus.illegal_o};

  function automatic logic [18:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] alu,
                                     input logic [1:0] imm, input logic ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
  endfunction

  function automatic logic [18:0] w_fetch(input logic rdy, input logic [1:0] imm);
    return cw(rdy, 1'b0, 1'b0, rdy, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
  endfunction

  function automatic logic [18:0] w_dec(input logic [1:0] imm, input logic ill);
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, ill);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_cw(input string tag, input logic [18:0] exp);
    #1;
    check_eq(tag, 32'(obs_w), 32'(exp));
  endtask

  // One 4-cycle ALU instruction; the caller has already advanced into FETCH
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [2:0] alu);
    bus.op_i = op; bus.funct3_i = f3; bus.funct7b5_i = f7;
    exp_cw({tag, "_fetch"}, w_fetch(1'b1, 2'b00));
    tick(); exp_cw({tag, "_dec"}, w_dec(2'b00, 1'b0));
    tick(); exp_cw({tag, "_exec"},
                   cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                      (op == OP_I) ? 2'b01 : 2'b00, alu, 2'b00, 1'b0));
    tick(); exp_cw({tag, "_wb"}, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00,
                                    3'b000, 2'b00, 1'b0));
    tick();
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic pcw);
    bus.op_i = OP_BR; bus.funct3_i = f3; bus.zero_i = z;
    exp_cw({tag, "_fetch"}, w_fetch(1'b1, 2'b10));
    tick(); exp_cw({tag, "_dec"}, w_dec(2'b10, 1'b0));
    tick(); exp_cw({tag, "_br"}, cw(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                                    3'b001, 2'b10, 1'b0));
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    bus.op_i = OP_LW; bus.funct3_i = 3'b010; bus.funct7b5_i = 1'b0;
    bus.zero_i = 1'b0; bus.mem_ready_i = 1'b1;
    tick(); tick();
    exp_cw("rst_fetch", w_fetch(1'b1, 2'b00));
    bus.mem_ready_i = 1'b0;
    exp_cw("rst_fetch_nrdy", w_fetch(1'b0, 2'b00));
    bus.mem_ready_i = 1'b1;
    rst_i = 1'b0;

    // lw: 5 cycles
    exp_cw("lw_fetch", w_fetch(1'b1, 2'b00));
    tick(); exp_cw("lw_dec", w_dec(2'b00, 1'b0));
    tick(); exp_cw("lw_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    tick(); exp_cw("lw_memread", cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    tick(); exp_cw("lw_memwb", cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 0));

    // sw with a fetch stall and a 3-cycle write stall
    tick(); bus.op_i = OP_SW; bus.mem_ready_i = 1'b0;
    exp_cw("sw_fetch_stall", w_fetch(1'b0, 2'b01));
    tick(); bus.mem_ready_i = 1'b1;
    exp_cw("sw_fetch", w_fetch(1'b1, 2'b01));
    tick(); exp_cw("sw_dec", w_dec(2'b01, 1'b0));
    tick(); exp_cw("sw_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    for (int i = 0; i < 3; i++) begin
      tick(); bus.mem_ready_i = 1'b0;
      exp_cw("sw_memwrite_stall", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    end
    tick(); bus.mem_ready_i = 1'b1;
    exp_cw("sw_memwrite", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    tick();

    run_alu("r_sub",  OP_R, 3'b000, 1'b1, 3'b001);
    run_alu("i_addi", OP_I, 3'b000, 1'b1, 3'b000);
    run_alu("r_slt",  OP_R, 3'b010, 1'b0, 3'b101);
    run_alu("r_or",   OP_R, 3'b110, 1'b0, 3'b011);
    run_alu("i_andi", OP_I, 3'b111, 1'b0, 3'b010);
    run_alu("r_xor",  OP_R, 3'b100, 1'b1, 3'b000);

    run_branch("beq_z1", 3'b000, 1'b1, 1'b1);
    run_branch("beq_z0", 3'b000, 1'b0, 1'b0);
    run_branch("bne_z1", 3'b001, 1'b1, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b1);

    // jal
    bus.op_i = OP_JAL;
    exp_cw("jal_fetch", w_fetch(1'b1, 2'b11));
    tick(); exp_cw("jal_dec", w_dec(2'b11, 1'b0));
    tick(); exp_cw("jal_jal", cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0));
    tick(); exp_cw("jal_wb", cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 0));

    // Unsupported opcode and unsupported branch funct3
    tick(); bus.op_i = OP_LUI;
    exp_cw("lui_fetch", w_fetch(1'b1, 2'b00));
    tick(); exp_cw("lui_dec", w_dec(2'b00, 1'b1));
    tick(); bus.op_i = OP_BR; bus.funct3_i = 3'b010;
    exp_cw("brill_fetch", w_fetch(1'b1, 2'b10));
    tick(); exp_cw("brill_dec", w_dec(2'b10, 1'b1));

    // Asynchronous reset in the middle of a stalled store
    tick(); bus.op_i = OP_SW;
    exp_cw("rst_sw_fetch", w_fetch(1'b1, 2'b01));
    tick(); exp_cw("rst_sw_dec", w_dec(2'b01, 1'b0));
    tick(); exp_cw("rst_sw_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    tick(); bus.mem_ready_i = 1'b0;
    exp_cw("rst_sw_memwrite", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    #2; rst_i = 1'b1;
    exp_cw("rst_async", w_fetch(1'b0, 2'b01));
    bus.mem_ready_i = 1'b1;
    exp_cw("rst_async_rdy", w_fetch(1'b1, 2'b01));
    tick(); exp_cw("rst_held", w_fetch(1'b1, 2'b01));
    rst_i = 1'b0;
    tick(); exp_cw("post_rst_dec", w_dec(2'b01, 1'b0));
    tick(); exp_cw("post_rst_memadr", cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0));
    tick(); exp_cw("post_rst_memwrite", cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));
    tick(); exp_cw("post_rst_fetch", w_fetch(1'b1, 2'b01));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
